// File: rtl/aes_pkg.sv
// Shared AES definitions: block types, FSM states, round count,
// inverse S-box, GF(2^8) helpers and the column-major byte mapping.
package aes_pkg;

  typedef logic [7:0]   aesByte;
  typedef logic [31:0]  aesWord;
  typedef logic [127:0] aesBlock;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsmState;

  localparam logic [3:0] AES_NR = 4'd10;

  // Entry i of this packed array is InvSBox(i); index 0 is the leftmost byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic aesByte xtime(input aesByte a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; with a constant b this folds to a few XORs.
  function automatic aesByte gmul(input aesByte a, input aesByte b);
    aesByte p;
    aesByte x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte (row, col) occupies bits [127-8*(4*col+row) -: 8]; this is its LSB.
  function automatic logic [6:0] byteLsb(input logic [1:0] row, input logic [1:0] col);
    return {~{col, row}, 3'b000};
  endfunction

  function automatic aesByte getByte(input aesBlock blk, input logic [1:0] row,
                                     input logic [1:0] col);
    return blk[byteLsb(row, col) +: 8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on the last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] blockIn,
  input  logic [127:0] roundKey,
  input  logic         lastRound,
  output logic [127:0] blockOut
);

  aesBlock addedKey;
  aesBlock mixed;

  // Row r is rotated right by r, so output column c takes input column c-r.
  always_comb begin
    addedKey = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        addedKey[byteLsb(2'(r), 2'(c)) +: 8] =
          INV_SBOX[getByte(blockIn, 2'(r), 2'(c - r))] ^ getByte(roundKey, 2'(r), 2'(c));
      end
    end
  end

  // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mixed[byteLsb(2'(r), 2'(c)) +: 8] =
          gmul(getByte(addedKey, 2'(r),     2'(c)), 8'h0e) ^
          gmul(getByte(addedKey, 2'(r + 1), 2'(c)), 8'h0b) ^
          gmul(getByte(addedKey, 2'(r + 2), 2'(c)), 8'h0d) ^
          gmul(getByte(addedKey, 2'(r + 3), 2'(c)), 8'h09);
      end
    end
  end

  assign blockOut = lastRound ? addedKey : mixed;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// fetched by index from an external key bank, valid/ready on both sides.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic [3:0]   o_keyIndex,
  input  logic [127:0] i_roundKey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
);

  fsmState state;
  fsmState stateNext;
  logic [3:0] rnd;
  aesBlock stateReg;
  aesBlock roundOut;
  logic lastRound;

  assign lastRound = (rnd == 4'd0);

  aes_inv_round uRound (
    .blockIn  (stateReg),
    .roundKey (i_roundKey),
    .lastRound(lastRound),
    .blockOut (roundOut)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic: accept, count rounds down to 0, wait for the consumer.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (i_valid)   stateNext = ROUND;
      ROUND:   if (lastRound) stateNext = DONE;
      DONE:    if (i_ready)   stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  // Moore outputs: handshake flags and the key index requested from the bank.
  always_comb begin
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_keyIndex = 4'd0;
    case (state)
      IDLE: begin
        o_ready    = 1'b1;
        o_keyIndex = AES_NR;
      end
      ROUND:   o_keyIndex = rnd;
      DONE:    o_valid    = 1'b1;
      default: o_keyIndex = AES_NR;
    endcase
  end

  // Working state and round counter; the decrement stops at round 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stateReg <= '0;
      rnd      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            stateReg <= i_data ^ i_roundKey;
            rnd      <= AES_NR - 4'd1;
          end
        end
        ROUND: begin
          if (!lastRound) begin
            stateReg <= roundOut;
            rnd      <= rnd - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Plaintext register, loaded only by the final round and held otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          o_data <= '0;
    else if (state == ROUND && lastRound)  o_data <= roundOut;
  end

endmodule
